// File: rtl/lcd_pkg.sv
// Shared constants and SPI state encoding for the ST7735 LCD interface blocks.
// Used by the SPI writer, the init/control sequencer and the bench.
package lcd_pkg;

    localparam int          DC_BIT    = 8;
    localparam logic [8:0]  DATA_IDLE = 9'h100;

    localparam int unsigned CLK_DIV_DEF    = 2;
    localparam int unsigned GAP_CYCLES_DEF = 2;

    typedef enum logic [5:0] {
        ST_IDLE  = 6'b000001,
        ST_SETUP = 6'b000010,
        ST_SHIFT = 6'b000100,
        ST_HOLD  = 6'b001000,
        ST_DONE  = 6'b010000,
        ST_GAP   = 6'b100000
    } spi_state_e;

endpackage

// File: rtl/lcd_spi_tick.sv
// Half-period timer: single-cycle tick every CLK_DIV cycles while enabled.
// The count clears whenever the timer is disabled.
module lcd_spi_tick #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic en,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == LAST);
        cnt_d = cnt_q + 8'd1;
        if (!en || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lcd_spi_write.sv
// Byte-level SPI mode-0 transmitter for the ST7735: sends {dc, byte} MSB first
// and pulses wr_done once per byte so the sequencer can advance.
module lcd_spi_write
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_DIV    = CLK_DIV_DEF,
    parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       en_write,
    input  logic [8:0] data,
    output logic       wr_done,
    output logic       busy,
    output logic       lcd_cs,
    output logic       lcd_sclk,
    output logic       lcd_mosi,
    output logic       lcd_dc
);

    spi_state_e state_q, state_d;
    logic [3:0] half_q, half_d;
    logic [7:0] gap_q, gap_d;
    logic [7:0] sr_q, sr_d;
    logic       cs_q, cs_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic       dc_q, dc_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;

    logic tick;
    logic tick_en;
    logic gap_last;
    logic capture;

    assign tick_en  = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
    assign gap_last = (gap_q == 8'(GAP_CYCLES - 1));
    // The last GAP edge doubles as an IDLE edge so back-to-back bytes run at the minimum period.
    assign capture  = en_write && ((state_q == ST_IDLE) || ((state_q == ST_GAP) && gap_last));

    lcd_spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .en      (tick_en),
        .tick    (tick)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            half_q  <= '0;
            gap_q   <= '0;
            sr_q    <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            dc_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            gap_q   <= gap_d;
            sr_q    <= sr_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            dc_q    <= dc_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (en_write) state_d = ST_SETUP;
            ST_SETUP: if (tick) state_d = ST_SHIFT;
            ST_SHIFT: if (tick && (half_q == 4'd15)) state_d = ST_HOLD;
            ST_HOLD:  if (tick) state_d = ST_DONE;
            ST_DONE:  state_d = ST_GAP;
            ST_GAP:   if (gap_last) state_d = en_write ? ST_SETUP : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cs_d   = cs_q;
        sclk_d = sclk_q;
        mosi_d = mosi_q;
        dc_d   = dc_q;
        sr_d   = sr_q;
        half_d = half_q;
        gap_d  = '0;
        done_d = 1'b0;
        busy_d = (state_d != ST_IDLE);

        case (state_q)
            ST_SHIFT: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    half_d = half_q + 4'd1;
                    // Falling edge: present the next bit; after bit 0 MOSI just holds.
                    if (sclk_q && (half_q != 4'd15)) begin
                        mosi_d = sr_q[6];
                        sr_d   = {sr_q[6:0], 1'b0};
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    done_d = 1'b1;
                    cs_d   = 1'b1;
                end
            end
            ST_GAP: begin
                gap_d = gap_last ? 8'd0 : gap_q + 8'd1;
            end
            default: ;
        endcase

        if (capture) begin
            sr_d   = data[7:0];
            dc_d   = data[DC_BIT];
            mosi_d = data[7];
            cs_d   = 1'b0;
            half_d = '0;
        end
    end

    assign wr_done  = done_q;
    assign busy     = busy_q;
    assign lcd_cs   = cs_q;
    assign lcd_sclk = sclk_q;
    assign lcd_mosi = mosi_q;
    assign lcd_dc   = dc_q;

endmodule

// File: tb/tb_lcd_spi_write.sv
// Directed bench for lcd_spi_write: default instance plus a CLK_DIV=1 instance,
// decoding the SPI bus and checking byte content and timing.
module tb_lcd_spi_write;
    import lcd_pkg::*;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       en0 = 1'b0;
    logic       en1 = 1'b0;
    logic [8:0] data = DATA_IDLE;
    logic       sel = 1'b0;

    logic done0, busy0, cs0, sclk0, mosi0, dc0;
    logic done1, busy1, cs1, sclk1, mosi1, dc1;
    logic o_done, o_busy, o_cs, o_sclk, o_mosi, o_dc;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int         ob_tcap, ob_tdone, ob_ndone, ob_nrise, ob_gmin, ob_gmax;
    logic [7:0] ob_rx;
    logic       ob_dc, ob_cs;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    lcd_spi_write #(.CLK_DIV(CLK_DIV_DEF), .GAP_CYCLES(GAP_CYCLES_DEF)) dut0 (
        .sys_clk (sys_clk), .sys_rst (sys_rst), .en_write (en0), .data (data),
        .wr_done (done0), .busy (busy0), .lcd_cs (cs0), .lcd_sclk (sclk0),
        .lcd_mosi (mosi0), .lcd_dc (dc0)
    );

    lcd_spi_write #(.CLK_DIV(1), .GAP_CYCLES(2)) dut1 (
        .sys_clk (sys_clk), .sys_rst (sys_rst), .en_write (en1), .data (data),
        .wr_done (done1), .busy (busy1), .lcd_cs (cs1), .lcd_sclk (sclk1),
        .lcd_mosi (mosi1), .lcd_dc (dc1)
    );

    assign o_done = sel ? done1 : done0;
    assign o_busy = sel ? busy1 : busy0;
    assign o_cs   = sel ? cs1   : cs0;
    assign o_sclk = sel ? sclk1 : sclk0;
    assign o_mosi = sel ? mosi1 : mosi0;
    assign o_dc   = sel ? dc1   : dc0;

    // Bus decoder: called at a negedge before the capture edge; records capture,
    // rising-edge MOSI samples and wr_done, then runs `extra` cycles past wr_done.
    task automatic observe(input int budget, input int extra, input bit drop_en);
        logic pcs, psclk;
        int   t_rise, left;
        ob_tcap = -1; ob_tdone = -1; ob_ndone = 0; ob_nrise = 0;
        ob_gmin = 1000; ob_gmax = 0; ob_rx = 8'h00; ob_dc = 1'b0; ob_cs = 1'b0;
        t_rise = -1; left = -1;
        pcs = o_cs; psclk = o_sclk;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (drop_en && i == 0) begin
                en0  = 1'b0;
                data = 9'h0FF;
            end
            if (pcs && !o_cs && ob_tcap < 0) ob_tcap = cyc;
            if (!psclk && o_sclk) begin
                ob_rx = {ob_rx[6:0], o_mosi};
                ob_nrise++;
                if (t_rise >= 0) begin
                    if (cyc - t_rise < ob_gmin) ob_gmin = cyc - t_rise;
                    if (cyc - t_rise > ob_gmax) ob_gmax = cyc - t_rise;
                end
                t_rise = cyc;
            end
            if (o_done) begin
                ob_ndone++;
                if (ob_tdone < 0) begin
                    ob_tdone = cyc;
                    ob_dc    = o_dc;
                    ob_cs    = o_cs;
                    left     = extra;
                end
            end
            pcs = o_cs; psclk = o_sclk;
            if (left == 0) break;
            if (left > 0) left--;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge sys_clk);
        checks++; if (cs0 !== 1'b1) begin errors++; $display("FAIL rst_cs: got %b expected 1", cs0); end
        checks++; if (sclk0 !== 1'b0) begin errors++; $display("FAIL rst_sclk: got %b expected 0", sclk0); end
        checks++; if (mosi0 !== 1'b0) begin errors++; $display("FAIL rst_mosi: got %b expected 0", mosi0); end
        checks++; if (dc0 !== 1'b0) begin errors++; $display("FAIL rst_dc: got %b expected 0", dc0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL rst_wr_done: got %b expected 0", done0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy0); end
        checks++; if (cs1 !== 1'b1 || sclk1 !== 1'b0) begin errors++; $display("FAIL rst_div1: got cs=%b sclk=%b expected cs=1 sclk=0", cs1, sclk1); end
    endtask

    task automatic test_single();
        data = 9'h011;
        en0  = 1'b1;
        sys_rst = 1'b0;
        observe(80, 0, 1'b0);
        en0 = 1'b0;
        checks++; if (ob_tcap < 0) begin errors++; $display("FAIL single_capture: got none expected cs fall"); end
        checks++; if (ob_rx !== 8'h11) begin errors++; $display("FAIL single_byte: got %h expected 11", ob_rx); end
        checks++; if (ob_nrise != 8) begin errors++; $display("FAIL single_rises: got %0d expected 8", ob_nrise); end
        checks++; if (ob_dc !== 1'b0) begin errors++; $display("FAIL single_dc: got %b expected 0", ob_dc); end
        checks++; if (ob_tdone - ob_tcap != 36) begin errors++; $display("FAIL single_latency: got %0d expected 36", ob_tdone - ob_tcap); end
        checks++; if (ob_cs !== 1'b1) begin errors++; $display("FAIL single_cs_at_done: got %b expected 1", ob_cs); end
        checks++; if (ob_gmin != 4 || ob_gmax != 4) begin errors++; $display("FAIL single_sclk_period: got %0d..%0d expected 4", ob_gmin, ob_gmax); end
        @(negedge sys_clk);
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b expected 0", o_done); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] words [3];
        int t_prev;
        words[0] = 9'h0B1; words[1] = 9'h101; words[2] = 9'h12C;
        repeat (6) @(negedge sys_clk);
        t_prev = -1;
        en0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data = words[k];
            observe(80, 0, 1'b0);
            checks++; if ({ob_dc, ob_rx} !== words[k]) begin errors++; $display("FAIL b2b_word%0d: got %h expected %h", k, {ob_dc, ob_rx}, words[k]); end
            if (k > 0) begin
                checks++; if (ob_tcap - t_prev != 39) begin errors++; $display("FAIL b2b_period%0d: got %0d expected 39", k, ob_tcap - t_prev); end
            end
            t_prev = ob_tcap;
            @(negedge sys_clk);
            checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL b2b_done_width%0d: got %b expected 0", k, o_done); end
        end
        en0 = 1'b0;
        data = DATA_IDLE;
    endtask

    task automatic test_div1();
        repeat (6) @(negedge sys_clk);
        sel  = 1'b1;
        data = 9'h1A5;
        en1  = 1'b1;
        observe(60, 0, 1'b0);
        en1 = 1'b0;
        checks++; if (ob_rx !== 8'hA5) begin errors++; $display("FAIL div1_byte: got %h expected a5", ob_rx); end
        checks++; if (ob_tdone - ob_tcap != 18) begin errors++; $display("FAIL div1_latency: got %0d expected 18", ob_tdone - ob_tcap); end
        checks++; if (ob_gmin != 2 || ob_gmax != 2) begin errors++; $display("FAIL div1_sclk_period: got %0d..%0d expected 2", ob_gmin, ob_gmax); end
        checks++; if (ob_dc !== 1'b1) begin errors++; $display("FAIL div1_dc: got %b expected 1", ob_dc); end
        checks++; if (ob_nrise != 8) begin errors++; $display("FAIL div1_rises: got %0d expected 8", ob_nrise); end
        repeat (6) @(negedge sys_clk);
        sel  = 1'b0;
        data = DATA_IDLE;
    endtask

    task automatic test_pulse();
        repeat (6) @(negedge sys_clk);
        data = 9'h03C;
        en0  = 1'b1;
        observe(100, 20, 1'b1);
        checks++; if (ob_rx !== 8'h3C) begin errors++; $display("FAIL pulse_byte: got %h expected 3c", ob_rx); end
        checks++; if (ob_ndone != 1) begin errors++; $display("FAIL pulse_done_count: got %0d expected 1", ob_ndone); end
        checks++; if (ob_nrise != 8) begin errors++; $display("FAIL pulse_rises: got %0d expected 8", ob_nrise); end
        checks++; if (ob_tdone - ob_tcap != 36) begin errors++; $display("FAIL pulse_latency: got %0d expected 36", ob_tdone - ob_tcap); end
        checks++; if (o_cs !== 1'b1 || o_sclk !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL pulse_idle_bus: got cs=%b sclk=%b busy=%b expected 1 0 0", o_cs, o_sclk, o_busy);
        end
        data = DATA_IDLE;
    endtask

    task automatic test_reset_mid_byte();
        int waited, nd;
        logic cs_rose;
        repeat (6) @(negedge sys_clk);
        data = 9'h05A;
        en0  = 1'b1;
        waited = 0;
        while (o_cs !== 1'b0 && waited < 5) begin
            @(negedge sys_clk);
            waited++;
        end
        en0 = 1'b0;
        checks++; if (o_cs !== 1'b0) begin errors++; $display("FAIL rstmid_capture: got cs=%b expected 0", o_cs); end
        repeat (9) @(negedge sys_clk);
        checks++; if (o_sclk !== 1'b1 || o_busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got sclk=%b busy=%b expected 1 1", o_sclk, o_busy); end
        #1 sys_rst = 1'b1;
        #1;
        checks++; if (o_cs !== 1'b1 || o_sclk !== 1'b0 || o_mosi !== 1'b0 || o_dc !== 1'b0) begin
            errors++; $display("FAIL rstmid_async: got cs=%b sclk=%b mosi=%b dc=%b expected 1 0 0 0", o_cs, o_sclk, o_mosi, o_dc);
        end
        checks++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: got busy=%b done=%b expected 0 0", o_busy, o_done); end
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        nd = 0; cs_rose = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge sys_clk);
            if (o_done) nd++;
            if (!o_cs) cs_rose = 1'b1;
        end
        checks++; if (nd != 0 || cs_rose) begin errors++; $display("FAIL rstmid_no_done: got done=%0d cs_low=%b expected 0 0", nd, cs_rose); end
        data = 9'h129;
        en0  = 1'b1;
        observe(80, 0, 1'b0);
        en0 = 1'b0;
        checks++; if ({ob_dc, ob_rx} !== 9'h129) begin errors++; $display("FAIL rstmid_next_word: got %h expected 129", {ob_dc, ob_rx}); end
        checks++; if (ob_tdone - ob_tcap != 36) begin errors++; $display("FAIL rstmid_next_latency: got %0d expected 36", ob_tdone - ob_tcap); end
    endtask

    task automatic test_gap();
        int t_prev;
        repeat (6) @(negedge sys_clk);
        data = 9'h077;
        en0  = 1'b1;
        observe(80, 0, 1'b0);
        t_prev = ob_tcap;
        checks++; if (ob_rx !== 8'h77) begin errors++; $display("FAIL gap_first_byte: got %h expected 77", ob_rx); end
        data = 9'h0AA;
        @(negedge sys_clk);
        checks++; if (o_cs !== 1'b1 || o_busy !== 1'b1) begin errors++; $display("FAIL gap_hold_off: got cs=%b busy=%b expected 1 1", o_cs, o_busy); end
        data = 9'h0BB;
        @(negedge sys_clk);
        checks++; if (o_cs !== 1'b1) begin errors++; $display("FAIL gap_no_capture: got cs=%b expected 1", o_cs); end
        data = 9'h1C3;
        observe(80, 0, 1'b0);
        en0 = 1'b0;
        checks++; if (ob_tcap - t_prev != 39) begin errors++; $display("FAIL gap_capture_time: got %0d expected 39", ob_tcap - t_prev); end
        checks++; if ({ob_dc, ob_rx} !== 9'h1C3) begin errors++; $display("FAIL gap_captured_word: got %h expected 1c3", {ob_dc, ob_rx}); end
        data = DATA_IDLE;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_div1();
        test_pulse();
        test_reset_mid_byte();
        test_gap();
        repeat (4) @(negedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
